// File: rtl/sys_bus_xbar.sv
// sys_bus_xbar: registered single-master to NUM_SLV-slave bus with base/mask decode,
// wait states, timeout and decode-error response. Stats counters under BUS_XBAR_STATS_EN.
module sys_bus_xbar #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {64'h0000_0000_2000_0000, 64'h0000_0000_1000_0000,
                                                   64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {4{64'hFFFF_FFFF_F000_0000}},
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m_req,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  input  logic [2:0]                m_rd_ctrl,
  input  logic [2:0]                m_wr_ctrl,
  output logic                      m_ready,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_err,
  output logic [NUM_SLV-1:0]        s_req,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [2:0]                s_rd_ctrl,
  output logic [2:0]                s_wr_ctrl,
  input  logic [NUM_SLV-1:0]        s_ack,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  output logic [31:0]               stat_txn,
  output logic [31:0]               stat_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t              state_q, state_d;
  logic [NUM_SLV-1:0]  req_d, hit;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d, rdata_d, sel_rdata;
  logic [2:0]          rd_d, wr_d;
  logic                ready_d, err_d, found, ack_hit;
  logic [15:0]         cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    req_d     = s_req;
    addr_d    = s_addr;
    wdata_d   = s_wdata;
    rd_d      = s_rd_ctrl;
    wr_d      = s_wr_ctrl;
    ready_d   = 1'b0;
    rdata_d   = m_rdata;
    err_d     = m_err;
    cnt_d     = cnt_q;
    hit       = '0;
    found     = 1'b0;
    sel_rdata = '0;

    // Lowest-indexed matching window wins when windows overlap.
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!found && ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
      if (s_req[i]) sel_rdata = s_rdata[i*DATA_W +: DATA_W];
    end
    ack_hit = |(s_ack & s_req);

    case (state_q)
      IDLE: begin
        if (m_req && (m_rd_ctrl != 3'd0 || m_wr_ctrl != 3'd0)) begin
          if ((m_rd_ctrl != 3'd0 && m_wr_ctrl != 3'd0) || !found) begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            req_d   = hit;
            addr_d  = m_addr;
            wdata_d = m_wdata;
            rd_d    = m_rd_ctrl;
            wr_d    = m_wr_ctrl;
            cnt_d   = '0;
          end
        end
      end
      ACCESS: begin
        // An ack on the timeout edge still completes as a normal data response.
        if (ack_hit) begin
          state_d = RESP;
          req_d   = '0;
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = (s_rd_ctrl != 3'd0) ? sel_rdata : '0;
        end else if (cnt_q + 16'd1 == TIMEOUT_C) begin
          state_d = RESP;
          req_d   = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_req     <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_rd_ctrl <= '0;
      s_wr_ctrl <= '0;
      m_ready   <= 1'b0;
      m_rdata   <= '0;
      m_err     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_req     <= req_d;
      s_addr    <= addr_d;
      s_wdata   <= wdata_d;
      s_rd_ctrl <= rd_d;
      s_wr_ctrl <= wr_d;
      m_ready   <= ready_d;
      m_rdata   <= rdata_d;
      m_err     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef BUS_XBAR_STATS_EN
  logic [31:0] txn_q, errc_q;

  // Saturating counters, updated on the cycle the response strobe is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_q  <= '0;
      errc_q <= '0;
    end else if (m_ready) begin
      if (txn_q != 32'hFFFF_FFFF) txn_q <= txn_q + 32'd1;
      if (m_err && errc_q != 32'hFFFF_FFFF) errc_q <= errc_q + 32'd1;
    end
  end

  assign stat_txn = txn_q;
  assign stat_err = errc_q;
`else
  assign stat_txn = '0;
  assign stat_err = '0;
`endif

endmodule

// File: tb/tb_sys_bus_xbar.sv
// tb_sys_bus_xbar: table vectors, hand-written corner sequences and random transactions
// checked against a transaction-level model; stats expectations follow BUS_XBAR_STATS_EN.
module tb_sys_bus_xbar;

  localparam int TMO   = 8;
  localparam int BOUND = TMO + 6;
`ifdef BUS_XBAR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_req;
  logic [63:0]  m_addr, m_wdata;
  logic [2:0]   m_rd_ctrl, m_wr_ctrl;
  logic         m_ready;
  logic [63:0]  m_rdata;
  logic         m_err;
  logic [3:0]   s_req;
  logic [63:0]  s_addr, s_wdata;
  logic [2:0]   s_rd_ctrl, s_wr_ctrl;
  logic [3:0]   s_ack;
  logic [255:0] s_rdata;
  logic [31:0]  stat_txn, stat_err;

  sys_bus_xbar #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rd_ctrl(m_rd_ctrl), .m_wr_ctrl(m_wr_ctrl),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rd_ctrl(s_rd_ctrl), .s_wr_ctrl(s_wr_ctrl),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .stat_txn(stat_txn), .stat_err(stat_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  addr;
    logic [2:0]   rd;
    logic [2:0]   wr;
    logic [63:0]  wdata;
    int           delay;
    bit           stray;
    logic [255:0] rvec;
  } req_t;

  typedef struct {
    int          lat;
    bit          err;
    logic [63:0] rdata;
    logic [3:0]  sreq;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [63:0] wdata;
    int          delay;
    logic [63:0] data;
    bit          stray;
    int          lat;
    bit          err;
    logic [63:0] rdata;
    logic [3:0]  sreq;
  } vec_t;

  int checks   = 0;
  int errors   = 0;
  int exp_txn  = 0;
  int exp_errc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input req_t rq);
    m_req     = 1'b1;
    m_addr    = rq.addr;
    m_wdata   = rq.wdata;
    m_rd_ctrl = rq.rd;
    m_wr_ctrl = rq.wr;
    s_rdata   = rq.rvec;
    s_ack     = '0;
  endtask

  // Address map as ranges: ROM/DRAM window, DRAM, UART, GPIO.
  function automatic int decodeSlave(input logic [63:0] a);
    if (a < 64'h1000_0000) return 0;
    if (a >= 64'h8000_0000 && a < 64'h9000_0000) return 1;
    if (a >= 64'h1000_0000 && a < 64'h2000_0000) return 2;
    if (a >= 64'h2000_0000 && a < 64'h3000_0000) return 3;
    return -1;
  endfunction

  // Latency is counted in cycles from the request edge to the m_ready cycle.
  function automatic exp_t modelTxn(input req_t rq);
    exp_t ex;
    int   idx;
    idx = decodeSlave(rq.addr);
    ex  = '{-1, 1'b0, 64'h0, 4'h0};
    if (rq.rd == 3'd0 && rq.wr == 3'd0) return ex;
    ex.lat = 1;
    ex.err = 1'b1;
    if ((rq.rd != 3'd0 && rq.wr != 3'd0) || idx < 0) return ex;
    ex.sreq = 4'(1 << idx);
    if (rq.delay >= 0 && rq.delay < TMO) begin
      ex.lat   = rq.delay + 2;
      ex.err   = 1'b0;
      ex.rdata = (rq.rd != 3'd0) ? rq.rvec[idx*64 +: 64] : 64'h0;
    end else begin
      ex.lat = TMO + 1;
    end
    return ex;
  endfunction

  function automatic req_t vecToReq(input vec_t v);
    req_t r;
    r.addr  = v.addr;
    r.rd    = v.rd;
    r.wr    = v.wr;
    r.wdata = v.wdata;
    r.delay = v.delay;
    r.stray = v.stray;
    for (int j = 0; j < 4; j++)
      r.rvec[j*64 +: 64] = v.sreq[j] ? v.data : {$urandom, $urandom};
    return r;
  endfunction

  function automatic req_t randomReq();
    req_t r;
    int   region, kind;
    logic [63:0] off;
    off    = 64'($urandom_range(0, 32'h0FFF_FFFF));
    region = $urandom_range(0, 4);
    case (region)
      0: r.addr = off;
      1: r.addr = 64'h8000_0000 + off;
      2: r.addr = 64'h1000_0000 + off;
      3: r.addr = 64'h2000_0000 + off;
      default: r.addr = ($urandom_range(0, 1) == 0) ? 64'h4000_0000 + off
                                                     : {$urandom | 32'h1, 32'h0} + off;
    endcase
    kind = $urandom_range(0, 9);
    r.rd = 3'd0;
    r.wr = 3'd0;
    if (kind == 1) begin
      r.rd = 3'($urandom_range(1, 7));
      r.wr = 3'($urandom_range(1, 7));
    end else if (kind >= 2 && kind <= 5) begin
      r.rd = 3'($urandom_range(1, 7));
    end else if (kind >= 6) begin
      r.wr = 3'($urandom_range(1, 7));
    end
    r.wdata = {$urandom, $urandom};
    r.delay = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 9);
    r.stray = (decodeSlave(r.addr) > 0) && ($urandom_range(0, 3) == 0);
    for (int j = 0; j < 4; j++) r.rvec[j*64 +: 64] = {$urandom, $urandom};
    return r;
  endfunction

  // Drives one transaction and plays the slaves: the selected slave acks once,
  // `delay` cycles after s_req becomes visible. skew=1 when issued during RESP.
  task automatic runTxn(input string tag, input req_t rq, input exp_t ex, input int skew, input bit tail);
    int          elat, lat, high;
    logic [63:0] rdata;
    logic        err;
    elat  = (ex.lat < 0) ? -1 : ex.lat + skew;
    lat   = -1;
    high  = 0;
    rdata = '0;
    err   = 1'b0;
    applyStimulus(rq);
    for (int c = 1; c <= BOUND + skew; c++) begin
      @(negedge clk);
      s_ack = '0;
      if (rq.stray) s_ack[0] = 1'b1;
      if (skew > 0 && c == 1) checkOutput($sformatf("%s.bubble", tag), 64'(s_req), 64'h0);
      if (c == 1 + skew) begin
        checkOutput($sformatf("%s.s_req", tag), 64'(s_req), 64'(ex.sreq));
        if (ex.sreq != 4'h0) begin
          checkOutput($sformatf("%s.s_addr", tag), s_addr, rq.addr);
          checkOutput($sformatf("%s.s_wdata", tag), s_wdata, rq.wdata);
          checkOutput($sformatf("%s.s_ctrl", tag), 64'({s_rd_ctrl, s_wr_ctrl}), 64'({rq.rd, rq.wr}));
        end
      end
      if (s_req != 4'h0) high++;
      if (m_ready) begin
        lat   = c;
        rdata = m_rdata;
        err   = m_err;
        break;
      end
      if (rq.delay >= 0 && c == 1 + skew + rq.delay) s_ack = s_ack | s_req;
    end
    m_req = 1'b0;
    s_ack = '0;
    checkOutput($sformatf("%s.latency", tag), 64'(lat), 64'(elat));
    checkOutput($sformatf("%s.s_req_cycles", tag), 64'(high), 64'((ex.sreq != 4'h0) ? elat - 1 - skew : 0));
    if (ex.lat > 0) begin
      checkOutput($sformatf("%s.m_rdata", tag), rdata, ex.rdata);
      checkOutput($sformatf("%s.m_err", tag), 64'(err), 64'(ex.err));
      exp_txn++;
      if (ex.err) exp_errc++;
    end
    if (tail) begin
      @(negedge clk);
      checkOutput($sformatf("%s.ready_pulse", tag), 64'(m_ready), 64'h0);
      checkOutput($sformatf("%s.s_req_idle", tag), 64'(s_req), 64'h0);
      checkOutput($sformatf("%s.stat_txn", tag), 64'(stat_txn), STATS ? 64'(exp_txn) : 64'h0);
      checkOutput($sformatf("%s.stat_err", tag), 64'(stat_err), STATS ? 64'(exp_errc) : 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[11];
    req_t rq, rq2;
    exp_t ex;
    bit   seen;

    rst_n = 1'b0; m_req = 1'b0; m_addr = '0; m_wdata = '0;
    m_rd_ctrl = '0; m_wr_ctrl = '0; s_ack = '0; s_rdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.s_req", 64'(s_req), 64'h0);
    checkOutput("reset.m_ready", 64'(m_ready), 64'h0);
    checkOutput("reset.m_err", 64'(m_err), 64'h0);
    checkOutput("reset.m_rdata", m_rdata, 64'h0);
    checkOutput("reset.s_addr", s_addr, 64'h0);
    checkOutput("reset.s_wdata", s_wdata, 64'h0);
    checkOutput("reset.s_ctrl", 64'({s_rd_ctrl, s_wr_ctrl}), 64'h0);
    checkOutput("reset.stats", 64'({stat_txn, stat_err}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // addr, rd, wr, wdata, delay, slave data, stray, latency, err, rdata, s_req
    vecs[0]  = '{64'h8000_0010, 3'd3, 3'd0, 64'h0,    3, 64'hDEAD_BEEF_0123_4567, 1'b0, 5, 1'b0, 64'hDEAD_BEEF_0123_4567, 4'b0010};
    vecs[1]  = '{64'h1000_0004, 3'd0, 3'd1, 64'h41,   0, 64'hFFFF_0000_1234_5678, 1'b0, 2, 1'b0, 64'h0, 4'b0100};
    vecs[2]  = '{64'h4000_0000, 3'd3, 3'd0, 64'h0,    0, 64'h0,                  1'b0, 1, 1'b1, 64'h0, 4'b0000};
    vecs[3]  = '{64'h2000_0000, 3'd2, 3'd0, 64'h0,   -1, 64'h1,                  1'b0, 9, 1'b1, 64'h0, 4'b1000};
    vecs[4]  = '{64'h8000_0100, 3'd3, 3'd0, 64'h0,    7, 64'h1122_3344_5566_7788, 1'b1, 9, 1'b0, 64'h1122_3344_5566_7788, 4'b0010};
    vecs[5]  = '{64'h0000_0000, 3'd1, 3'd1, 64'h5,    0, 64'h0,                  1'b0, 1, 1'b1, 64'h0, 4'b0000};
    vecs[6]  = '{64'h0000_0040, 3'd4, 3'd0, 64'h0,    1, 64'hCAFE_F00D_0000_0001, 1'b0, 3, 1'b0, 64'hCAFE_F00D_0000_0001, 4'b0001};
    vecs[7]  = '{64'h2000_0100, 3'd0, 3'd3, 64'h55AA, 6, 64'h9,                  1'b0, 8, 1'b0, 64'h0, 4'b1000};
    vecs[8]  = '{64'h8FFF_FFF8, 3'd3, 3'd0, 64'h0,    8, 64'h7,                  1'b0, 9, 1'b1, 64'h0, 4'b0010};
    vecs[9]  = '{64'h8000_0000, 3'd0, 3'd0, 64'h3,    0, 64'h0,                  1'b0, -1, 1'b0, 64'h0, 4'b0000};
    vecs[10] = '{64'h1_0000_0000, 3'd3, 3'd0, 64'h0,  0, 64'h0,                  1'b0, 1, 1'b1, 64'h0, 4'b0000};

    for (int i = 0; i < 11; i++) begin
      rq = vecToReq(vecs[i]);
      ex = '{vecs[i].lat, vecs[i].err, vecs[i].rdata, vecs[i].sreq};
      runTxn($sformatf("vec%0d", i), rq, ex, 0, 1'b1);
    end

    // Back-to-back: second request presented while m_ready is high.
    rq  = '{64'h8000_0200, 3'd3, 3'd0, 64'h0, 0, 1'b0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}};
    rq2 = '{64'h1000_0008, 3'd0, 3'd2, 64'h77, 1, 1'b0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}};
    runTxn("b2b_a", rq, modelTxn(rq), 0, 1'b0);
    runTxn("b2b_b", rq2, modelTxn(rq2), 1, 1'b1);

    // Reset on the second wait cycle of a GPIO read that would never be acked.
    rq = '{64'h2000_0000, 3'd3, 3'd0, 64'h0, -1, 1'b0, 256'h0};
    applyStimulus(rq);
    @(negedge clk);
    checkOutput("rst.s_req_before", 64'(s_req), 64'h8);
    @(negedge clk);
    rst_n = 1'b0;
    m_req = 1'b0;
    @(negedge clk);
    checkOutput("rst.s_req_after", 64'(s_req), 64'h0);
    checkOutput("rst.m_ready", 64'(m_ready), 64'h0);
    rst_n    = 1'b1;
    exp_txn  = 0;
    exp_errc = 0;
    seen     = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_ready) seen = 1'b1;
    end
    checkOutput("rst.no_ready", 64'(seen), 64'h0);
    checkOutput("rst.stats", 64'({stat_txn, stat_err}), 64'h0);
    rq = '{64'h0, 3'd2, 3'd0, 64'h0, 2, 1'b0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}};
    runTxn("rom_after_rst", rq, modelTxn(rq), 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      rq = randomReq();
      runTxn($sformatf("rnd%0d", n), rq, modelTxn(rq), 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
